// File: rtl/muldiv_ctrl_if.sv
// Operand/result bundle between the execute stage and the multiply/divide
// sequencer. The execute stage drives the request side and the sequencer
// returns status and the HI/LO results.
interface muldiv_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       OP;
  logic [WIDTH-1:0] In1;
  logic [WIDTH-1:0] In2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output start, OP, In1, In2,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, OP, In1, In2,
    output busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// Iterative multiply/divide sequencer for mult, multu, div and divu.
// Operands are reduced to magnitudes at accept, processed one bit per clock
// (shift-add for multiply, restoring shift-subtract for divide) and
// sign-corrected in a final FIX cycle that writes the HI/LO registers.
module muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input logic          clock,
  input logic          reset_n,
  muldiv_ctrl_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_e;

  // Sequencer state.
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;

  // Datapath: acc holds {hi,lo} of the product, or {rem,quo} when dividing.
  // opnd holds the multiplicand magnitude or the divisor magnitude.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   raw_a_q, raw_a_d;

  // Architectural outputs.
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dbz_q, dbz_d;

  // Operand magnitudes presented at accept time.
  logic             in_neg_a, in_neg_b;
  logic [WIDTH-1:0] in_mag_a, in_mag_b;

  // One iteration of each algorithm.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH+1:0]   div_trial;
  logic [2*WIDTH-1:0] div_next;

  // Sign-corrected results for the FIX cycle.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Magnitude reduction of the incoming operands; unsigned ops pass through.
  always_comb begin
    in_neg_a = ~bus.OP[0] & bus.In1[WIDTH-1];
    in_neg_b = ~bus.OP[0] & bus.In2[WIDTH-1];
    in_mag_a = in_neg_a ? (~bus.In1 + 1'b1) : bus.In1;
    in_mag_b = in_neg_b ? (~bus.In2 + 1'b1) : bus.In2;
  end

  // Single shift-add and restoring shift-subtract steps over acc.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                        : {1'b0, acc_q[2*WIDTH-1:1]};
    // Shifted remainder needs WIDTH+1 bits; one more bit carries the borrow.
    div_trial = {1'b0, acc_q[2*WIDTH-1:WIDTH-1]} - {2'b00, opnd_q};
    div_next  = div_trial[WIDTH+1] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                   : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  end

  // Sign correction applied when the iterations are finished.
  always_comb begin
    prod_fix = (neg_a_q ^ neg_b_q) ? (~acc_q + 1'b1) : acc_q;
    quo_fix  = (neg_a_q ^ neg_b_q) ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    rem_fix  = neg_a_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
  end

  // Next-state and datapath control for IDLE -> RUN -> FIX -> IDLE.
  always_comb begin
    // NOTE: every _d gets a hold value first so no path through the case
    // leaves a variable unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    raw_a_d  = raw_a_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d  = S_RUN;
          cnt_d    = '0;
          is_div_d = bus.OP[1];
          neg_a_d  = in_neg_a;
          neg_b_d  = in_neg_b;
          // Multiply shifts the multiplier out of the low half; divide
          // shifts the dividend out of the low half into the remainder.
          acc_d    = bus.OP[1] ? {{WIDTH{1'b0}}, in_mag_a} : {{WIDTH{1'b0}}, in_mag_b};
          opnd_d   = bus.OP[1] ? in_mag_b : in_mag_a;
          raw_a_d  = bus.In1;
          busy_d   = 1'b1;
          dbz_d    = 1'b0;
        end
      end

      S_RUN: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (!is_div_q) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (opnd_q == '0) begin
          // Division by zero returns the dividend untouched and all-ones.
          hi_d  = raw_a_q;
          lo_d  = '1;
          dbz_d = 1'b1;
        end else begin
          // -2^(WIDTH-1) / -1 wraps naturally to 0x80.. with zero remainder.
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      // NOTE: datapath registers are reset too, so no X ever reaches hi/lo
      // even though the next accept overwrites them anyway.
      acc_q    <= '0;
      opnd_q   <= '0;
      raw_a_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed by the combinational block.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      raw_a_q  <= raw_a_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dbz_q    <= dbz_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: the driver pushes the hand-computed
// result and completion cycle of each accepted op; a negedge monitor pops
// and compares whenever done is presented.
module tb_muldiv_ctrl;

  localparam int W       = 32;
  localparam int LATENCY = W + 1;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t mon_e;

  muldiv_ctrl_if #(.WIDTH(W)) bus ();

  muldiv_ctrl #(.WIDTH(W)) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter used to time-stamp accept and done.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("hi", 64'(bus.hi), 64'(mon_e.hi));
        check("lo", 64'(bus.lo), 64'(mon_e.lo));
        check("div_by_zero", 64'(bus.div_by_zero), 64'(mon_e.dbz));
        check("done_cycle", 64'(cyc), 64'(mon_e.cyc));
        check("busy_with_done", 64'(bus.busy), 64'd0);
      end
    end
  end

  // Called at a negedge: presents one op, lets it be accepted, then scrambles
  // the inputs since they only need to be valid at the accept edge.
  task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edbz,
                      input bit push);
    exp_t e;
    bus.start = 1'b1;
    bus.OP    = op;
    bus.In1   = a;
    bus.In2   = b;
    @(posedge clk);
    #1;
    if (push) begin
      e.hi  = ehi;
      e.lo  = elo;
      e.dbz = edbz;
      e.cyc = cyc + LATENCY;
      sb.push_back(e);
    end
    bus.start = 1'b0;
    bus.OP    = 2'(~op);
    bus.In1   = 32'hA5A5_5A5A;
    bus.In2   = 32'h0000_0000;
  endtask

  // Bounded wait that returns at the negedge on which done is seen.
  task automatic wait_done(input string name);
    for (int i = 0; i < 3 * LATENCY; i++) begin
      @(negedge clk);
      if (bus.done) return;
    end
    check({name, "_timeout"}, 64'd1, 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_done"}, 64'(bus.done), 64'd0);
    check({tag, "_hi"}, 64'(bus.hi), 64'd0);
    check({tag, "_lo"}, 64'(bus.lo), 64'd0);
    check({tag, "_dbz"}, 64'(bus.div_by_zero), 64'd0);
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.OP    = 2'b00;
    bus.In1   = '0;
    bus.In2   = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // multu max*max, counting busy cycles along the way.
    send(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b1);
    n = 0;
    for (int i = 0; i < 3 * LATENCY; i++) begin
      @(negedge clk);
      if (bus.busy) n++;
      else break;
    end
    check("busy_cycles", 64'(n), 64'(LATENCY));
    @(negedge clk);

    // mult -3 * 7
    send(2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b1);
    wait_done("mult_neg");
    @(negedge clk);

    // mult 0x80000000 * 0x80000000
    send(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b1);
    wait_done("mult_min");
    @(negedge clk);

    // div -7 / 2
    send(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b1);
    wait_done("div_neg");
    @(negedge clk);

    // divu 100 / 7 with a stray start (mult 9*9) ten cycles in.
    send(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    bus.start = 1'b1;
    bus.OP    = 2'b00;
    bus.In1   = 32'd9;
    bus.In2   = 32'd9;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("divu_ignored_start");
    @(negedge clk);

    // div overflow: 0x80000000 / -1
    send(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b1);
    wait_done("div_ovf");
    @(negedge clk);

    // divu by zero, then mult 2*3 accepted back-to-back in the done cycle.
    send(2'b11, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 1'b1);
    wait_done("divu_zero");
    send(2'b00, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 1'b1);
    check("dbz_cleared_at_accept", 64'(bus.div_by_zero), 64'd0);
    check("hi_held_after_accept", 64'(bus.hi), 64'h1234);
    check("lo_held_after_accept", 64'(bus.lo), 64'hFFFF_FFFF);
    wait_done("mult_b2b");
    @(negedge clk);

    // Leave non-zero hi/lo and the flag set before the reset test.
    send(2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 1'b1);
    wait_done("divu_zero2");
    @(negedge clk);

    // Reset fifteen cycles into a div: outputs clear without a clock edge.
    send(2'b10, 32'd100, 32'hFFFF_FFFD, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (14) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * LATENCY) @(negedge clk);
    check_all_zero("idle_after_reset");

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
